// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: memory-stage load/store bus controller with pipeline stall and lane-aligned read data
// Ports: clk_i/reset_i (sync, active-high); memory-stage inputs valid_m_i, mem_write_m_i, mem_read_m_i,
//   alu_result_m_i, write_data_m_i, width_src_m_i, hold_m_i; bus side bus_req_o/bus_gnt_i,
//   bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_rvalid_i, bus_rdata_i; results read_data_m_o,
//   stall_mem_o, misaligned_o, bus_err_o.
// Optional feature: define DMEM_TIMEOUT_EN for a TIMEOUT_CYCLES watchdog on REQ/RESP.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_m_i,
  input  logic        mem_write_m_i,
  input  logic        mem_read_m_i,
  input  logic [31:0] alu_result_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [2:0]  width_src_m_i,
  input  logic        hold_m_i,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] read_data_m_o,
  output logic        stall_mem_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0]  w_off;
  logic        w_access, w_wr, w_mis, w_start, w_busy, w_to, w_unused;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        r_mis;
  logic [31:0] r_rdata;
  assign w_off    = alu_result_m_i[1:0];
  assign w_access = valid_m_i & (mem_read_m_i | mem_write_m_i);
  assign w_wr     = mem_write_m_i;
  // width code follows funct3: [1:0] 00 byte, 01 half, 1x word; bit 2 (unsigned) only matters to width reduction
  assign w_mis    = width_src_m_i[1] ? |w_off : width_src_m_i[0] & w_off[0];
  assign w_be     = width_src_m_i[1] ? 4'hF : width_src_m_i[0] ? 4'b0011 << w_off : 4'b0001 << w_off;
  assign w_wdata  = width_src_m_i[1] ? write_data_m_i :
                    width_src_m_i[0] ? {2{write_data_m_i[15:0]}} : {4{write_data_m_i[7:0]}};
  assign w_start  = r_state == IDLE & w_access;
  assign w_busy   = r_state == REQ | r_state == RESP;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  // abort only when the last allowed cycle passes without the awaited handshake
  assign w_to = w_busy & r_cnt == CW'(TIMEOUT_CYCLES - 1) & ~(r_state == REQ ? bus_gnt_i : bus_rvalid_i);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_next != r_state ? '0 : r_cnt + CW'(w_busy);
      r_err <= w_to;
    end
  end
  assign bus_err_o = r_err;
  assign w_unused  = width_src_m_i[2];
`else
  assign w_to      = 1'b0;
  assign bus_err_o = 1'b0;
  assign w_unused  = &{1'b0, width_src_m_i[2], TIMEOUT_CYCLES != 0};
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_access) w_next = w_mis ? DONE : REQ;
      REQ:     if (bus_gnt_i) w_next = w_wr ? DONE : RESP; else if (w_to) w_next = DONE;
      RESP:    if (bus_rvalid_i | w_to) w_next = DONE;
      default: if (!hold_m_i) w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_mis   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_mis   <= w_start & w_mis;
      r_rdata <= (w_start & w_mis) | w_to ? '0 :
                 r_state == RESP & bus_rvalid_i ? bus_rdata_i >> {w_off, 3'b000} : r_rdata;
    end
  end
  assign bus_req_o     = r_state == REQ;
  assign bus_we_o      = bus_req_o & w_wr;
  assign bus_addr_o    = bus_req_o ? {alu_result_m_i[31:2], 2'b00} : '0;
  assign bus_be_o      = bus_req_o ? w_be : '0;
  assign bus_wdata_o   = bus_req_o ? w_wdata : '0;
  assign stall_mem_o   = w_start & ~w_mis | w_busy;
  assign read_data_m_o = r_rdata;
  assign misaligned_o  = r_mis;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized and directed transaction checks of dmem_access_ctrl against a transaction-level model
module tb_dmem_access_ctrl;
`ifdef DMEM_TIMEOUT_EN
  localparam int TC = 8;
`else
  localparam int TC = 256;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_i, valid_m_i, mem_write_m_i, mem_read_m_i, hold_m_i, bus_gnt_i, bus_rvalid_i;
  logic [31:0] alu_result_m_i, write_data_m_i, bus_rdata_i;
  logic [2:0]  width_src_m_i;
  logic        bus_req_o, bus_we_o, stall_mem_o, misaligned_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, read_data_m_o;
  logic [3:0]  bus_be_o;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_rd = '0;
  dmem_access_ctrl #(.TIMEOUT_CYCLES(TC)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_m_i(valid_m_i), .mem_write_m_i(mem_write_m_i),
    .mem_read_m_i(mem_read_m_i), .alu_result_m_i(alu_result_m_i), .write_data_m_i(write_data_m_i),
    .width_src_m_i(width_src_m_i), .hold_m_i(hold_m_i), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .read_data_m_o(read_data_m_o), .stall_mem_o(stall_mem_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o)
  );

  task automatic run_txn(input logic w, input logic r, input logic [2:0] ws, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv, input int gd, input int rdl,
                         input int h, input string tag);
    logic ld, mis;
    logic [1:0] off;
    logic [3:0] ebe;
    logic [31:0] ewd, erd;
    logic [4:0] got, exp;
    int s, n, rv_i;
    ld   = !w;
    off  = a[1:0];
    mis  = (ws[1:0] == 2'd1 && off % 2 == 1) || (ws[1:0] == 2'd2 && off != 0);
    ebe  = ws[1:0] == 2'd0 ? 4'(1 << off) : ws[1:0] == 2'd1 ? 4'(3 << off) : 4'hF;
    ewd  = ws[1:0] == 2'd0 ? wd[7:0] * 32'h01010101 : ws[1:0] == 2'd1 ? wd[15:0] * 32'h00010001 : wd;
    erd  = rdv >> (8 * off);
    valid_m_i = 1'b1; mem_write_m_i = w; mem_read_m_i = r; width_src_m_i = ws;
    alu_result_m_i = a; write_data_m_i = wd;
    if (mis) begin
      hold_m_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      #1 got = {stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o};
      n_cmp++;
      if (got !== 5'b00000) begin n_bad++; $display("FAIL %s idle: got %b want 00000", tag, got); end
      @(negedge clk);
      valid_m_i = 1'b0;
      #1 got = {stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o};
      exp_rd = '0;
      n_cmp++;
      if (got !== 5'b00010 || read_data_m_o !== exp_rd)
        begin n_bad++; $display("FAIL %s pulse: got %b/%h want 00010/%h", tag, got, read_data_m_o, exp_rd); end
      @(negedge clk);
      #1 got = {stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o};
      n_cmp++;
      if (got !== 5'b00000) begin n_bad++; $display("FAIL %s after: got %b want 00000", tag, got); end
      @(negedge clk);
      return;
    end
    s    = w ? 2 + gd : 3 + gd + rdl;
    n    = s + 1 + h;
    rv_i = 2 + gd + rdl;
    for (int i = 0; i < n; i++) begin
      hold_m_i     = i < s ? 1'($urandom % 2) : 1'(i < s + h);
      bus_gnt_i    = i == 1 + gd;
      bus_rvalid_i = (ld && i >= 2 + gd && i <= rv_i) ? 1'(i == rv_i) : 1'($urandom % 2);
      bus_rdata_i  = (ld && i == rv_i) ? rdv : $urandom;
      #1;
      exp = {i < s, i >= 1 && i <= 1 + gd, w && i >= 1 && i <= 1 + gd, 2'b00};
      got = {stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL %s cyc%0d ctl: got %b want %b", tag, i, got, exp); end
      if (exp[3]) begin
        n_cmp++;
        if ({bus_addr_o, bus_be_o, bus_wdata_o} !== {a & ~32'd3, ebe, ewd})
          begin n_bad++; $display("FAIL %s cyc%0d bus: got %h/%b/%h want %h/%b/%h", tag, i,
                                  bus_addr_o, bus_be_o, bus_wdata_o, a & ~32'd3, ebe, ewd); end
      end
      if (i == s) begin
        if (ld) exp_rd = erd;
        n_cmp++;
        if (read_data_m_o !== exp_rd)
          begin n_bad++; $display("FAIL %s rdata: got %h want %h", tag, read_data_m_o, exp_rd); end
      end
      @(negedge clk);
    end
    valid_m_i = 1'b0; hold_m_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_m_i = 1'b0; mem_write_m_i = 1'b0; mem_read_m_i = 1'b0; hold_m_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; alu_result_m_i = '0;
    write_data_m_i = '0; width_src_m_i = 3'b010;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #1 n_cmp++;
    if ({stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o, bus_addr_o, bus_be_o, bus_wdata_o, read_data_m_o} !== '0)
      begin n_bad++; $display("FAIL reset: got req=%b stall=%b addr=%h rdata=%h want all 0",
                              bus_req_o, stall_mem_o, bus_addr_o, read_data_m_o); end
    exp_rd = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0, "word_load");
    run_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'hA5, 32'h0, 0, 0, 0, "byte_store");
    run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'h12345678, 0, 0, 0, "half_load");
    run_txn(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0, "mis_word");
    run_txn(1'b1, 1'b0, 3'b101, 32'h3, 32'h1234, 32'h0, 0, 0, 0, "mis_half");
    run_txn(1'b0, 1'b1, 3'b100, 32'h2F1, 32'h0, 32'hCAFEF00D, 2, 3, 1, "byte_load");
  endtask

  task automatic test_hold();
    run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, 0, 3, "hold_store");
    run_txn(1'b1, 1'b1, 3'b001, 32'h302, 32'hBEEF, 32'h0, 1, 0, 1, "write_wins");
  endtask

  task automatic test_random();
    logic [2:0] codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic w;
    for (int k = 0; k < 60; k++) begin
      w = 1'($urandom % 2);
      run_txn(w, w ? 1'($urandom % 2) : 1'b1, codes[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "random");
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] got, exp;
    valid_m_i = 1'b1; mem_read_m_i = 1'b1; mem_write_m_i = 1'b0; width_src_m_i = 3'b010;
    alu_result_m_i = 32'h80; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; hold_m_i = 1'b0;
    for (int i = 0; i <= TC + 1; i++) begin
      #1 got = {stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o};
      exp = {i <= TC, i >= 1 && i <= TC, 1'b0, 1'b0, i == TC + 1};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL timeout cyc%0d: got %b want %b", i, got, exp); end
      @(negedge clk);
    end
    valid_m_i = 1'b0;
    exp_rd = '0;
    #1 n_cmp++;
    if ({bus_err_o, stall_mem_o, bus_req_o, read_data_m_o} !== {3'b000, exp_rd})
      begin n_bad++; $display("FAIL timeout_end: got err=%b rdata=%h want 0/%h", bus_err_o, read_data_m_o, exp_rd); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_resp();
    valid_m_i = 1'b1; mem_read_m_i = 1'b1; mem_write_m_i = 1'b0; width_src_m_i = 3'b010;
    alu_result_m_i = 32'h40; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; hold_m_i = 1'b0;
    @(negedge clk);
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0;
    #1 n_cmp++;
    if ({stall_mem_o, bus_req_o} !== 2'b10)
      begin n_bad++; $display("FAIL rst_resp in_resp: got %b want 10", {stall_mem_o, bus_req_o}); end
    reset_i = 1'b1; valid_m_i = 1'b0;
    @(negedge clk);
    #1 n_cmp++;
    if ({stall_mem_o, bus_req_o, bus_we_o, misaligned_o, bus_err_o, bus_addr_o, bus_be_o, bus_wdata_o, read_data_m_o} !== '0)
      begin n_bad++; $display("FAIL rst_resp zero: got req=%b stall=%b rdata=%h want all 0",
                              bus_req_o, stall_mem_o, read_data_m_o); end
    reset_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    bus_rvalid_i = 1'b0;
    #1 n_cmp++;
    if ({stall_mem_o, bus_req_o, read_data_m_o} !== 34'd0)
      begin n_bad++; $display("FAIL rst_resp discard: got stall=%b req=%b rdata=%h want 0/0/0",
                              stall_mem_o, bus_req_o, read_data_m_o); end
    exp_rd = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
